// File: rtl/usb_host_token_tx_if.sv
// Request/line bundle for the USB full-speed host token transmitter.
interface usb_host_token_tx_if;
  logic        start;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic [10:0] frame_number;
  logic        dplus_out;
  logic        dminus_out;
  logic        busy;
  logic        done;

  modport master (
    output start, pid, addr, endp, frame_number,
    input  dplus_out, dminus_out, busy, done
  );

  modport slave (
    input  start, pid, addr, endp, frame_number,
    output dplus_out, dminus_out, busy, done
  );
endinterface

// File: rtl/usb_host_token_tx.sv
// USB full-speed host token transmitter: SYNC/PID/FIELD/CRC5 with NRZI, bit stuffing and EOP.
// Define USB_HOST_TX_SOF_EN to send frame_number as FIELD for SOF tokens.
module usb_host_token_tx #(
  parameter int CLKS_PER_BIT = 8
) (
  input logic                 clk,
  input logic                 n_rst,
  usb_host_token_tx_if.slave  bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_FIELD, S_CRC, S_EOP_SE0, S_EOP_J
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    ones_q, ones_d;
  logic [4:0]    crc_q, crc_d;
  logic [3:0]    pid_q, pid_d;
  logic [10:0]   field_q, field_d;
  logic          dp_q, dp_d, dm_q, dm_d;
  logic          busy_q, busy_d, done_q, done_d;

  state_t        nstate;
  logic [3:0]    nidx;
  logic          raw;
  logic [7:0]    pid_byte;
  logic [10:0]   field_sel;
  logic          data_state;

`ifdef USB_HOST_TX_SOF_EN
  assign field_sel = (bus.pid == 4'b0101) ? bus.frame_number : {bus.endp, bus.addr};
`else
  logic unused_frame;
  assign unused_frame = ^bus.frame_number;
  assign field_sel    = {bus.endp, bus.addr};
`endif

  assign pid_byte   = {~pid_q, pid_q};
  assign data_state = (state_q == S_SYNC) || (state_q == S_PID) ||
                      (state_q == S_FIELD) || (state_q == S_CRC);

  // state_q/idx_q name the raw bit last sent; a stuffed bit leaves them unchanged
  always_comb begin
    nstate = state_q;
    nidx   = idx_q + 4'd1;
    case (state_q)
      S_SYNC:    if (idx_q == 4'd7)  begin nstate = S_PID;     nidx = '0; end
      S_PID:     if (idx_q == 4'd7)  begin nstate = S_FIELD;   nidx = '0; end
      S_FIELD:   if (idx_q == 4'd10) begin nstate = S_CRC;     nidx = '0; end
      S_CRC:     if (idx_q == 4'd4)  begin nstate = S_EOP_SE0; nidx = '0; end
      S_EOP_SE0: if (idx_q == 4'd1)  begin nstate = S_EOP_J;   nidx = '0; end
      default:   begin nstate = S_IDLE; nidx = '0; end
    endcase
  end

  always_comb begin
    case (nstate)
      S_SYNC:  raw = (nidx == 4'd7);
      S_PID:   raw = pid_byte[nidx[2:0]];
      S_FIELD: raw = field_q[nidx];
      S_CRC:   raw = ~crc_q[3'd4 - nidx[2:0]];
      default: raw = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    ones_d  = ones_q;
    crc_d   = crc_q;
    pid_d   = pid_q;
    field_d = field_q;
    dp_d    = dp_q;
    dm_d    = dm_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.start) begin
        state_d = S_SYNC;
        idx_d   = '0;
        timer_d = '0;
        ones_d  = '0;
        crc_d   = '1;
        pid_d   = bus.pid;
        field_d = field_sel;
        busy_d  = 1'b1;
        dp_d    = 1'b0;
        dm_d    = 1'b1;
      end
    end else if (timer_q != T_LAST) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = '0;
      if (data_state && ones_q == 3'd6) begin
        dp_d   = ~dp_q;
        dm_d   = dp_q;
        ones_d = '0;
      end else begin
        state_d = nstate;
        idx_d   = nidx;
        case (nstate)
          S_SYNC, S_PID, S_FIELD, S_CRC: begin
            if (!raw) begin
              dp_d = ~dp_q;
              dm_d = dp_q;
            end
            ones_d = raw ? ones_q + 3'd1 : 3'd0;
            if (nstate == S_FIELD)
              crc_d = {crc_q[3:0], 1'b0} ^ ((crc_q[4] ^ raw) ? 5'b00101 : 5'b00000);
          end
          S_EOP_SE0: begin dp_d = 1'b0; dm_d = 1'b0; end
          S_EOP_J:   begin dp_d = 1'b1; dm_d = 1'b0; end
          default: begin
            dp_d   = 1'b1;
            dm_d   = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      ones_q  <= '0;
      crc_q   <= '1;
      pid_q   <= '0;
      field_q <= '0;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      ones_q  <= ones_d;
      crc_q   <= crc_d;
      pid_q   <= pid_d;
      field_q <= field_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.dplus_out  = dp_q;
  assign bus.dminus_out = dm_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_usb_host_token_tx.sv
// Bench for usb_host_token_tx: directed and random tokens against a packet-level line model.
module tb_usb_host_token_tx;
  localparam int CPB = 8;
  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, SE0 = 2'b00;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  usb_host_token_tx_if bus();

  usb_host_token_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [1:0] exp_sym[$];
  bit         exp_raw[$];
  int         exp_stuff;
  logic [1:0] samp[$];
  bit         dec_raw[$];
  int         dec_stuff;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet model: raw bit list, then stuffing and NRZI, then EOP, one symbol per bit time
  function automatic void build(input logic [3:0] p, input logic [6:0] a,
                                input logic [3:0] e, input logic [10:0] f);
    logic [7:0]  pb;
    logic [10:0] fv;
    logic [4:0]  c;
    logic [1:0]  lvl;
    int          ones;
    exp_raw = {};
    for (int i = 0; i < 7; i++) exp_raw.push_back(1'b0);
    exp_raw.push_back(1'b1);
    pb = {~p, p};
    for (int i = 0; i < 8; i++) exp_raw.push_back(pb[i]);
    fv = {e, a};
`ifdef USB_HOST_TX_SOF_EN
    if (p == 4'h5) fv = f;
`else
    if (f == 11'h7FF && p == 4'hF) fv = {e, a};
`endif
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      exp_raw.push_back(fv[i]);
      if (c[4] ^ fv[i]) c = 5'((c << 1) ^ 5'h05);
      else              c = 5'(c << 1);
    end
    c = ~c;
    for (int i = 4; i >= 0; i--) exp_raw.push_back(c[i]);
    exp_sym = {};
    lvl = LJ;
    ones = 0;
    exp_stuff = 0;
    foreach (exp_raw[i]) begin
      if (!exp_raw[i]) lvl = (lvl == LJ) ? LK : LJ;
      exp_sym.push_back(lvl);
      ones = exp_raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = (lvl == LJ) ? LK : LJ;
        exp_sym.push_back(lvl);
        exp_stuff++;
        ones = 0;
      end
    end
    exp_sym.push_back(SE0);
    exp_sym.push_back(SE0);
    exp_sym.push_back(LJ);
  endfunction

  // Recover raw bits from the captured line, mid-bit samples, until SE0
  function automatic void decode();
    logic [1:0] prev, s;
    int ones;
    bit b;
    prev = LJ;
    ones = 0;
    dec_raw = {};
    dec_stuff = 0;
    for (int k = 0; k < samp.size() / CPB; k++) begin
      s = samp[k*CPB + CPB/2];
      if (s == SE0) break;
      b = (s == prev);
      prev = s;
      if (ones == 6) begin
        dec_stuff++;
        ones = 0;
      end else begin
        dec_raw.push_back(b);
        ones = b ? ones + 1 : 0;
      end
    end
  endfunction

  function automatic logic [31:0] pack(input bit q[$]);
    logic [31:0] v = '0;
    for (int i = 0; i < 32 && i < q.size(); i++) v[i] = q[i];
    return v;
  endfunction

  task automatic issue(input logic [3:0] p, input logic [6:0] a,
                       input logic [3:0] e, input logic [10:0] f);
    bus.pid = p;
    bus.addr = a;
    bus.endp = e;
    bus.frame_number = f;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic collect(input bit disturb);
    int cyc = 0;
    int dn = 0;
    int idx;
    logic [1:0] bad;
    samp = {};
    chk("busy_rise", 32'(bus.busy), 32'd1);
    while (bus.busy === 1'b1 && cyc < 3000) begin
      samp.push_back({bus.dplus_out, bus.dminus_out});
      if (bus.done !== 1'b0) dn++;
      if (disturb && cyc == 150) begin
        bus.start = 1'b1; bus.pid = 4'h9; bus.addr = 7'h55;
        bus.endp = 4'hA; bus.frame_number = 11'h7FF;
      end
      if (disturb && (cyc == 151 || cyc == 201)) bus.start = 1'b0;
      if (disturb && cyc == 200) bus.start = 1'b1;
      cyc++;
      @(negedge clk);
    end
    chk("busy_len", cyc, exp_sym.size() * CPB);
    chk("busy_len_formula", cyc, (35 + exp_stuff) * CPB);
    chk("done_during_busy", dn, 0);
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("idle_after_eop", 32'({bus.dplus_out, bus.dminus_out}), 32'(LJ));
    for (int k = 0; k < exp_sym.size(); k++) begin
      bad = exp_sym[k];
      for (int j = CPB - 1; j >= 0; j--) begin
        idx = k*CPB + j;
        if (idx >= samp.size()) bad = 2'bxx;
        else if (samp[idx] !== exp_sym[k]) bad = samp[idx];
      end
      chk($sformatf("line_bit%0d", k), 32'(bad), 32'(exp_sym[k]));
    end
  endtask

  task automatic quiet_cycle();
    @(negedge clk);
    chk("no_restart", 32'(bus.busy), 32'd0);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int se0_n, j_n, ok;
    logic [3:0] pids[4];
    pids[0] = 4'b0001; pids[1] = 4'b1001; pids[2] = 4'b1101; pids[3] = 4'b0101;
    bus.start = 1'b0; bus.pid = '0; bus.addr = '0; bus.endp = '0; bus.frame_number = '0;

    repeat (3) @(negedge clk);
    chk("rst_dp", 32'(bus.dplus_out), 32'd1);
    chk("rst_dm", 32'(bus.dminus_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // SETUP addr 0 endp 0
    build(4'b1101, 7'h00, 4'h0, 11'h000);
    issue(4'b1101, 7'h00, 4'h0, 11'h000);
    chk("first_bit_K", 32'({bus.dplus_out, bus.dminus_out}), 32'(LK));
    collect(1'b0);
    chk("setup_busy_280", samp.size(), 280);
    decode();
    chk("setup_sync", pack(dec_raw) & 32'hFF, 32'h80);
    chk("setup_bytes", pack(dec_raw) >> 8, 32'h0010002D);
    chk("setup_nbits", dec_raw.size(), 32);
    chk("setup_nstuff", dec_stuff, 0);
    se0_n = 0; j_n = 0;
    for (int i = 0; i < 24 && samp.size() >= 24; i++) begin
      if (i < 16 && samp[samp.size() - 24 + i] === SE0) se0_n++;
      if (i >= 16 && samp[samp.size() - 24 + i] === LJ) j_n++;
    end
    chk("eop_se0_cycles", se0_n, 16);
    chk("eop_j_cycles", j_n, 8);
    quiet_cycle();

    // IN addr 7F endp F: long runs of ones force stuffing
    build(4'b1001, 7'h7F, 4'hF, 11'h000);
    issue(4'b1001, 7'h7F, 4'hF, 11'h000);
    collect(1'b0);
    decode();
    chk("in_raw_stream", pack(dec_raw), pack(exp_raw));
    chk("in_nbits", dec_raw.size(), 32);
    chk("in_nstuff", dec_stuff, exp_stuff);
    quiet_cycle();

    // start and input changes while busy are ignored
    build(4'b1101, 7'h12, 4'h4, 11'h000);
    issue(4'b1101, 7'h12, 4'h4, 11'h000);
    collect(1'b1);
    quiet_cycle();
    repeat (20) @(negedge clk);
    chk("no_second_packet", 32'(bus.busy), 32'd0);

    // back-to-back: second start in the done cycle
    build(4'b0001, 7'h3C, 4'h2, 11'h000);
    issue(4'b0001, 7'h3C, 4'h2, 11'h000);
    collect(1'b0);
    build(4'b1001, 7'h41, 4'h7, 11'h000);
    issue(4'b1001, 7'h41, 4'h7, 11'h000);
    collect(1'b0);
    quiet_cycle();

    // SOF: frame_number is FIELD only when the feature is built in
    build(4'b0101, 7'h2A, 4'h3, 11'h001);
    issue(4'b0101, 7'h2A, 4'h3, 11'h001);
    collect(1'b0);
    decode();
    chk("sof_raw_stream", pack(dec_raw), pack(exp_raw));
    quiet_cycle();

    for (int n = 0; n < 6; n++) begin
      logic [3:0] p;
      logic [6:0] a;
      logic [3:0] e;
      logic [10:0] f;
      p = pids[$urandom_range(0, 3)];
      a = 7'($urandom);
      e = 4'($urandom);
      f = 11'($urandom);
      build(p, a, e, f);
      issue(p, a, e, f);
      collect(1'b0);
      quiet_cycle();
    end

    // asynchronous reset in the middle of SYNC
    issue(4'b1001, 7'h05, 4'h1, 11'h000);
    repeat (20) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_lines", 32'({bus.dplus_out, bus.dminus_out}), 32'(LJ));
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    ok = 1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 1'b0) ok = 0;
    end
    n_rst = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
          {bus.dplus_out, bus.dminus_out} !== LJ) ok = 0;
    end
    chk("midrst_quiet", ok, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
